// File: rtl/sigmoid_lut_arbiter.sv
// Round-robin arbiter sharing one sigmoid ROM between NUM_REQ neurons.
// Saturates sums to 16 bits, addresses the ROM, routes results back by tag.
module sigmoid_lut_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SUM_W   = 32,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*SUM_W-1:0] req_sum,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_q,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     busy
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int DEPTH = ROM_LAT + 1;

  localparam logic signed [SUM_W-1:0] SMAX = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] SMIN = SUM_W'(-32768);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      cand;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               run;
  logic               accept;
  logic               pipe_busy;

  logic               tag_v [DEPTH];
  logic [IW-1:0]      tag_i [DEPTH];

  logic signed [SUM_W-1:0] sel_sum;
  logic [15:0]             s16;
  logic [15:0]             code;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: drain waits for all in-flight lookups to leave
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (enable) state_n = RUN;
      end
      RUN: begin
        if (!enable) state_n = DRAIN;
      end
      DRAIN: begin
        if (enable) state_n = RUN;
        else if (!pipe_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM outputs: grants are only exposed while running
  always_comb begin
    run       = (state == RUN);
    req_ready = run ? gnt : '0;
  end

  // Round-robin search; nearest candidate after ptr is written last
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign accept = |(req_valid & req_ready);

  // Saturate the granted sum and convert to offset-binary code
  always_comb begin
    sel_sum = req_sum[gnt_idx*SUM_W +: SUM_W];
    if (sel_sum < SMIN) begin
      s16 = 16'h8000;
    end else if (sel_sum > SMAX) begin
      s16 = 16'h7fff;
    end else begin
      s16 = sel_sum[15:0];
    end
    code = {~s16[15], s16[14:0]};
  end

  // ROM address and rotation pointer update on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      ptr      <= IW'(NUM_REQ - 1);
    end else if (accept) begin
      rom_addr <= code[15 -: ADDR_W];
      ptr      <= gnt_idx;
    end
  end

  // Tag pipeline tracks who owns each lookup in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        tag_v[j] <= 1'b0;
        tag_i[j] <= '0;
      end
    end else begin
      tag_v[0] <= accept;
      tag_i[0] <= gnt_idx;
      for (int j = 1; j < DEPTH; j++) begin
        tag_v[j] <= tag_v[j-1];
        tag_i[j] <= tag_i[j-1];
      end
    end
  end

  // Any stage holding a live lookup
  always_comb begin
    pipe_busy = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      pipe_busy = pipe_busy | tag_v[j];
    end
  end

  // Completing tag captures ROM data and pulses its requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else if (tag_v[DEPTH-1]) begin
      rsp_valid <= NUM_REQ'(1) << tag_i[DEPTH-1];
      rsp_data  <= rom_q;
    end else begin
      rsp_valid <= '0;
    end
  end

  assign busy = (state != IDLE) | pipe_busy;

endmodule

// File: tb/tb_sigmoid_lut_arbiter.sv
// Scoreboard bench for sigmoid_lut_arbiter with a latency-modelled ROM.
// Reference model predicts grants, addresses, responses and busy.
module tb_sigmoid_lut_arbiter;

  localparam int NR = 4;
  localparam int SW = 32;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int RL = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [NR-1:0] req_valid;
  logic [NR*SW-1:0] req_sum;
  logic [NR-1:0] req_ready;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic [NR-1:0] rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          busy;

  sigmoid_lut_arbiter #(
    .NUM_REQ(NR), .SUM_W(SW), .ADDR_W(AW),
    .DATA_W(DW), .ROM_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_sum(req_sum),
    .req_ready(req_ready), .rom_addr(rom_addr),
    .rom_q(rom_q), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_fn(logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a;
    return t[11:4] ^ t[7:0] ^ 8'h5a;
  endfunction

  logic [AW-1:0] rom_pipe [RL];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_addr;
    for (int k = 1; k < RL; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_q = rom_fn(rom_pipe[RL-1]);

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
    int          due;
  } exp_t;

  exp_t q[$];

  int errors = 0;
  int checks = 0;

  int st;
  int ptr;
  int last_due;
  int acc_idx;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] last_data;

  logic [NR-1:0] vld;
  logic [SW-1:0] sm [NR];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] sat_addr(logic [SW-1:0] raw);
    longint s;
    int code;
    s = longint'($signed(raw));
    if (s < -32768) s = -32768;
    else if (s > 32767) s = 32767;
    code = int'(s) + 32768;
    return AW'(code >> (16 - AW));
  endfunction

  function automatic logic [NR-1:0] model_grant(
    logic [NR-1:0] v, int p, bit running);
    logic [NR-1:0] g;
    g = '0;
    if (running) begin
      for (int k = 1; k <= NR; k++) begin
        if (g == 0 && v[(p + k) % NR]) g[(p + k) % NR] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [SW-1:0] rnd_sum();
    int r;
    r = 0;
    case ($urandom_range(0, 3))
      0: r = int'($urandom);
      1: r = int'($urandom_range(0, 80000)) - 40000;
      2: r = ($urandom_range(0, 1) == 1) ? 32767 + int'($urandom_range(0, 2)) - 1
                                         : -32768 + int'($urandom_range(0, 2)) - 1;
      default: r = int'($urandom_range(0, 400)) - 200;
    endcase
    return SW'(r);
  endfunction

  task automatic model_reset();
    st        = M_IDLE;
    ptr       = NR - 1;
    last_due  = 0;
    exp_addr  = '0;
    last_data = '0;
    q.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = vld[i];
      req_sum[i*SW +: SW] = sm[i];
    end
  endtask

  task automatic tick();
    logic [NR-1:0] eg;
    int nst;
    bit empty;
    logic [AW-1:0] a;
    exp_t e;
    drive();
    #1;
    eg = model_grant(req_valid, ptr, st == M_RUN);
    chk("req_ready", 32'(req_ready), 32'(eg));
    empty = !(last_due > cyc);
    case (st)
      M_IDLE:  nst = enable ? M_RUN : M_IDLE;
      M_RUN:   nst = enable ? M_RUN : M_DRAIN;
      default: nst = enable ? M_RUN : (empty ? M_IDLE : M_DRAIN);
    endcase
    acc_idx = -1;
    for (int i = 0; i < NR; i++) if (eg[i]) acc_idx = i;
    if (acc_idx >= 0) begin
      a = sat_addr(req_sum[acc_idx*SW +: SW]);
      e.idx  = acc_idx;
      e.data = rom_fn(a);
      e.due  = cyc + RL + 2;
      q.push_back(e);
      exp_addr = a;
      ptr      = acc_idx;
      last_due = e.due;
    end
    st = nst;
    @(posedge clk);
    #1;
    chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
    chk("busy", 32'(busy), 32'((st != M_IDLE) || (last_due > cyc)));
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (q.size() > 0 && q[0].due < cyc) begin
          chk("rsp_missing", 32'(cyc), 32'(q[0].due));
          void'(q.pop_front());
        end
        if (rsp_valid != '0) begin
          if (q.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
          end else begin
            e = q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("rsp_latency", 32'(cyc), 32'(e.due));
            last_data = e.data;
          end
        end else begin
          chk("rsp_data_hold", 32'(rsp_data), 32'(last_data));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    vld    = '1;
    for (int i = 0; i < NR; i++) sm[i] = '0;
    drive();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    vld = '0;
    drive();
    rst = 1'b0;

    enable = 1'b1;
    vld    = 4'b0100;
    sm[2]  = '0;
    tick();
    tick();
    chk("addr_zero_sum", 32'(rom_addr), 32'h800);
    vld = '0;
    repeat (4) tick();

    vld = '1;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NR; i++) sm[i] = rnd_sum();
      tick();
    end
    vld = '0;
    repeat (4) tick();

    begin
      logic [SW-1:0] dir [4];
      logic [AW-1:0] dexp [4];
      dir[0] = SW'(-100000); dexp[0] = 12'h000;
      dir[1] = SW'(32767);   dexp[1] = 12'hfff;
      dir[2] = SW'(40000);   dexp[2] = 12'hfff;
      dir[3] = SW'(-32768);  dexp[3] = 12'h000;
      for (int t = 0; t < 4; t++) begin
        vld[0] = 1'b1;
        sm[0]  = dir[t];
        tick();
        chk("addr_sat", 32'(rom_addr), 32'(dexp[t]));
      end
      vld = '0;
      repeat (4) tick();
    end

    vld[1] = 1'b1;
    sm[1]  = rnd_sum();
    tick();
    sm[1]  = rnd_sum();
    enable = 1'b0;
    tick();
    sm[1]  = rnd_sum();
    repeat (2) tick();
    vld = '0;
    repeat (5) tick();
    chk("drain_to_idle", 32'(busy), 32'h0);

    enable = 1'b1;
    vld = 4'b0110;
    sm[1] = rnd_sum();
    sm[2] = rnd_sum();
    tick();
    tick();
    repeat (2) tick();
    vld = 4'b0110;
    tick();
    vld[acc_idx] = 1'b0;
    tick();
    vld = '0;
    drive();
    #2 rst = 1'b1;
    #1;
    chk("midrst_rom_addr", 32'(rom_addr), 32'h0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    vld = 4'b1001;
    sm[0] = rnd_sum();
    sm[3] = rnd_sum();
    tick();
    drive();
    #1 chk("first_grant_after_rst", 32'(req_ready), 32'h1);
    tick();
    vld[0] = 1'b0;
    drive();
    #1 chk("wrap_grant", 32'(req_ready), 32'h8);
    tick();
    vld = '0;
    repeat (5) tick();

    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (!vld[i] && $urandom_range(0, 2) == 0) begin
          vld[i] = 1'b1;
          sm[i]  = rnd_sum();
        end
      end
      enable = ($urandom_range(0, 9) != 0);
      tick();
      if (acc_idx >= 0) vld[acc_idx] = 1'b0;
    end

    vld    = '0;
    enable = 1'b0;
    repeat (8) tick();
    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    chk("final_busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sigmoid_lut_arbiter.md
Name: sigmoid_lut_arbiter

Overview:
- Shares one sigmoid lookup ROM (sigmoid_IP, 12-bit address, 8-bit data) between NUM_REQ neuron instances of a layer.
- Each neuron offers its pre-activation sum (weighted sum + bias) through a valid/ready handshake.
- The arbiter picks requesters round-robin, saturates each sum to 16 bits and converts it to a ROM address.
- It tracks in-flight lookups in a tag pipeline and returns each activation to the requester that issued it.
- Sits between the neuron accumulators and the single ROM instance of the layer.

Parameters:
- NUM_REQ, 4, number of requesting neurons (2..16).
- SUM_W, 32, width of signed pre-activation sum.
- ADDR_W, 12, ROM address width (top ADDR_W bits of the 16-bit offset code).
- DATA_W, 8, ROM data / activation width.
- ROM_LAT, 2, rising edges from rom_addr change until rom_q reflects it (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  high = grants allowed; low = stop granting and drain.
- req_valid  in  NUM_REQ  per-requester sum valid.
- req_sum  in  NUM_REQ*SUM_W  packed signed sums; requester i occupies bits [i*SUM_W +: SUM_W].
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_q  in  DATA_W  ROM output.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse, result for requester i.
- rsp_data  out  DATA_W  activation, shared by all requesters, qualified by rsp_valid.
- busy  out  1  high while state != IDLE or any lookup is in flight.

Behaviour:
- Reset (async, any time):
  - State = IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first.
  - Tag pipeline cleared, which discards any in-flight lookups.
  - rom_addr=0, rsp_valid=0, rsp_data=0, busy=0.
- FSM:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> RUN when enable=1.
  - DRAIN -> IDLE when the tag pipeline is empty.
  - Grants are issued only in RUN.
- Arbitration (RUN only):
  - Search req_valid starting at pointer+1 and wrap at NUM_REQ-1 -> 0.
  - The first set bit gets req_ready. At most one grant per cycle; a requester that never raises valid never blocks the others.
  - On accept (valid & ready sampled at edge E0), the pointer takes the granted index.
  - Requesters hold req_valid and req_sum stable until accepted; req_ready never depends on req_sum.
- Saturation and address, registered at E0:
  - s16 = -32768 if sum < -32768; 32767 if sum > 32767; otherwise sum.
  - code = s16 + 32768, unsigned 16 bits (offset binary).
  - rom_addr = code[15:16-ADDR_W].
  - rom_addr holds its value when no accept occurs.
  - The ROM contents are generated in this offset-binary order.
- Tag pipeline:
  - Depth ROM_LAT+1, each stage = {valid, index}.
  - On accept, stage 0 loads {1, index}; otherwise it loads {0, x}. The pipeline shifts every cycle.
- Response:
  - At edge E0+ROM_LAT+1, rsp_data <= rom_q and rsp_valid <= onehot(index).
  - Latency is exactly ROM_LAT+1 edges, independent of traffic. Back-to-back accepts give back-to-back responses in issue order.
  - rsp_valid=0 in every cycle with no completing tag; rsp_data holds its last value.
- Boundary cases:
  - enable falling in the same cycle as a request: that request is still accepted if the FSM is in RUN during that cycle.
  - In DRAIN, in-flight lookups complete normally.
  - Requester re-requesting while its own lookup is in flight: accepted. Each request gets exactly one response, in order.
  - Single requester continuously valid: granted every cycle, giving 100% throughput.
- busy = (state != IDLE) OR any tag-stage valid.

Test Plan:
- Reset then enable=1, only req 2 valid with sum=0 -> req_ready=0b0100 in that cycle; rom_addr=0x800 after E0; rsp_valid=0b0100 at E0+3 with rsp_data = rom_q sampled at E0+2.
- All 4 valid continuously -> grant order 0,1,2,3,0,1..., one grant per cycle; response pulses follow the same order 3 cycles later.
- Sums -100000, 32767, 40000, -32768 -> rom_addr 0x000, 0xFFF, 0xFFF, 0x000.
- Req 1 sends 3 back-to-back sums while enable drops after the 2nd accept -> exactly 2 responses; FSM goes DRAIN -> IDLE; busy falls one cycle after the last rsp_valid.
- Assert rst while 2 lookups are in flight -> no rsp_valid ever appears for them; outputs 0 immediately; the first grant after re-enable goes to requester 0.
- Requesters 0 and 3 valid, pointer=3 -> req 0 granted first, then req 3 on the next cycle (wrap).
